// File: rtl/switch_allocator.sv
// Round-robin wormhole switch allocator: one IDLE/BUSY FSM per output, path held until tail transfer.
// Optional per-output watchdog force-release enabled with the ALLOC_TIMEOUT_EN macro.
module switch_allocator #(
   parameter int INPUTS        = 4,
   parameter int OUTPUTS       = 4,
   parameter int REQUEST_WIDTH = 32,
   parameter int TIMEOUT       = 256
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [INPUTS-1:0]                req_valid,
   input  logic [INPUTS*REQUEST_WIDTH-1:0]  req_dest,
   input  logic [INPUTS-1:0]                valid_in,
   input  logic [INPUTS-1:0]                ready_in,
   input  logic [INPUTS-1:0]                tail_in,
   output logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect,
   output logic [OUTPUTS-1:0]               outputBusy,
   output logic [INPUTS-1:0]                PortReserved,
   output logic                             alloc_error
);

   localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
   localparam logic [REQUEST_WIDTH-1:0] NO_ROUTE = REQUEST_WIDTH'(INPUTS);

   if (INPUTS < 2 || TIMEOUT < 2) begin : g_param_check
      $error("switch_allocator: INPUTS and TIMEOUT must both be at least 2");
   end

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                   state_q [OUTPUTS];
   state_t                   state_d [OUTPUTS];
   logic [PTR_W-1:0]         owner_q [OUTPUTS];
   logic [PTR_W-1:0]         owner_d [OUTPUTS];
   logic [PTR_W-1:0]         ptr_q   [OUTPUTS];
   logic [PTR_W-1:0]         ptr_d   [OUTPUTS];
   logic [REQUEST_WIDTH-1:0] route_q [OUTPUTS];
   logic [REQUEST_WIDTH-1:0] route_d [OUTPUTS];
   logic [INPUTS-1:0]        reserved_q, reserved_d;
   logic                     err_q, err_d;
   logic [REQUEST_WIDTH-1:0] dest    [INPUTS];

   logic                     found;
   logic [PTR_W-1:0]         win;
   logic [PTR_W-1:0]         idx;
   logic [PTR_W:0]           sum;
   logic [PTR_W-1:0]         w;

`ifdef ALLOC_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0]         cnt_q [OUTPUTS];
   logic [CNT_W-1:0]         cnt_d [OUTPUTS];
`endif

   for (genvar i = 0; i < INPUTS; i++) begin : g_unpack
      assign dest[i] = req_dest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
   end

   for (genvar o = 0; o < OUTPUTS; o++) begin : g_pack
      assign routeSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = route_q[o];
      assign outputBusy[o] = (state_q[o] == BUSY);
   end

   assign PortReserved = reserved_q;
   assign alloc_error  = err_q;

   always_comb begin
      reserved_d = reserved_q;
      err_d      = 1'b0;
      found      = 1'b0;
      win        = '0;
      idx        = '0;
      sum        = '0;
      w          = '0;
      for (int o = 0; o < OUTPUTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         route_d[o] = route_q[o];
`ifdef ALLOC_TIMEOUT_EN
         cnt_d[o]   = cnt_q[o];
`endif
         case (state_q[o])
            IDLE: begin
               // Search upward from the pointer, wrapping modulo INPUTS (non-power-of-2 safe).
               found = 1'b0;
               win   = '0;
               for (int k = 0; k < INPUTS; k++) begin
                  sum = {1'b0, ptr_q[o]} + (PTR_W+1)'(k);
                  if (sum >= (PTR_W+1)'(INPUTS))
                     sum = sum - (PTR_W+1)'(INPUTS);
                  idx = sum[PTR_W-1:0];
                  if (!found && req_valid[idx] && !reserved_q[idx] &&
                      dest[idx] == REQUEST_WIDTH'(o)) begin
                     found = 1'b1;
                     win   = idx;
                  end
               end
               if (found) begin
                  state_d[o]      = BUSY;
                  owner_d[o]      = win;
                  route_d[o]      = REQUEST_WIDTH'(win);
                  reserved_d[win] = 1'b1;
`ifdef ALLOC_TIMEOUT_EN
                  cnt_d[o]        = '0;
`endif
               end
            end
            BUSY: begin
               w = owner_q[o];
               if (valid_in[w] && ready_in[w] && tail_in[w]) begin
                  state_d[o]    = IDLE;
                  route_d[o]    = NO_ROUTE;
                  reserved_d[w] = 1'b0;
                  ptr_d[o]      = (w == PTR_W'(INPUTS-1)) ? '0 : w + 1'b1;
               end
`ifdef ALLOC_TIMEOUT_EN
               else if (valid_in[w] && ready_in[w]) begin
                  cnt_d[o] = '0;
               end else if (cnt_q[o] == CNT_W'(TIMEOUT-1)) begin
                  // Watchdog release behaves exactly like a tail transfer.
                  state_d[o]    = IDLE;
                  route_d[o]    = NO_ROUTE;
                  reserved_d[w] = 1'b0;
                  ptr_d[o]      = (w == PTR_W'(INPUTS-1)) ? '0 : w + 1'b1;
                  err_d         = 1'b1;
               end else begin
                  cnt_d[o] = cnt_q[o] + 1'b1;
               end
`endif
            end
            default: state_d[o] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < OUTPUTS; o++) begin
            state_q[o] <= IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
            route_q[o] <= NO_ROUTE;
`ifdef ALLOC_TIMEOUT_EN
            cnt_q[o]   <= '0;
`endif
         end
         reserved_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int o = 0; o < OUTPUTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
            route_q[o] <= route_d[o];
`ifdef ALLOC_TIMEOUT_EN
            cnt_q[o]   <= cnt_d[o];
`endif
         end
         reserved_q <= reserved_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, grant/release, round-robin, parallel grants, reset mid-packet, watchdog.
module tb_switch_allocator;

   localparam int IN = 4;
   localparam int OUT = 4;
   localparam int RW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [IN-1:0]     req_valid;
   logic [IN*RW-1:0]  req_dest;
   logic [IN-1:0]     valid_in, ready_in, tail_in;
   logic [OUT*RW-1:0] routeSelect;
   logic [OUT-1:0]    outputBusy;
   logic [IN-1:0]     PortReserved;
   logic              alloc_error;

   int errors = 0;
   int checks = 0;

   switch_allocator #(
      .INPUTS(IN), .OUTPUTS(OUT), .REQUEST_WIDTH(RW), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_dest(req_dest),
      .valid_in(valid_in), .ready_in(ready_in), .tail_in(tail_in),
      .routeSelect(routeSelect), .outputBusy(outputBusy),
      .PortReserved(PortReserved), .alloc_error(alloc_error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] route(input int o);
      return routeSelect[o*RW +: RW];
   endfunction

   task automatic set_dest(input int i, input int d);
      req_dest[i*RW +: RW] = RW'(d);
   endtask

   task automatic hs(input logic [IN-1:0] v, input logic [IN-1:0] r, input logic [IN-1:0] t);
      valid_in = v;
      ready_in = r;
      tail_in  = t;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_dest = '0;
      hs(4'b0000, 4'b0000, 4'b0000);
      step();
      step();
      rst = 1'b0;

      // 1. reset state and quiet idle
      for (int o = 0; o < OUT; o++) chk($sformatf("reset_route%0d", o), route(o), 32'd4);
      chk("reset_busy", 32'(outputBusy), 32'h0);
      chk("reset_reserved", 32'(PortReserved), 32'h0);
      chk("reset_err", 32'(alloc_error), 32'h0);
      for (int c = 0; c < 10; c++) step();
      chk("idle_busy", 32'(outputBusy), 32'h0);
      chk("idle_route1", route(1), 32'd4);

      // 2. single grant, body flits, stalled tail, real tail
      req_valid = 4'b0100;
      set_dest(2, 1);
      step();
      chk("grant_busy", 32'(outputBusy), 32'b0010);
      chk("grant_route1", route(1), 32'd2);
      chk("grant_route0", route(0), 32'd4);
      chk("grant_reserved", 32'(PortReserved), 32'b0100);
      req_valid = 4'b0000;
      hs(4'b0100, 4'b0100, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("body_busy", 32'(outputBusy), 32'b0010);
         chk("body_reserved", 32'(PortReserved), 32'b0100);
      end
      hs(4'b0100, 4'b0000, 4'b0100);
      step();
      chk("stalled_tail_busy", 32'(outputBusy), 32'b0010);
      hs(4'b0100, 4'b0100, 4'b0100);
      step();
      chk("tail_busy", 32'(outputBusy), 32'h0);
      chk("tail_route1", route(1), 32'd4);
      chk("tail_reserved", 32'(PortReserved), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);

      // 3. round-robin on output 0 with single-flit packets
      req_valid = 4'b1011;
      set_dest(0, 0); set_dest(1, 0); set_dest(2, 0); set_dest(3, 0);
      hs(4'b1111, 4'b1111, 4'b1111);
      step();
      chk("rr_g1_route", route(0), 32'd0);
      chk("rr_g1_busy", 32'(outputBusy), 32'b0001);
      chk("rr_g1_res", 32'(PortReserved), 32'b0001);
      step();
      chk("rr_r1_busy", 32'(outputBusy), 32'h0);
      chk("rr_r1_route", route(0), 32'd4);
      chk("rr_r1_res", 32'(PortReserved), 32'h0);
      step();
      chk("rr_g2_route", route(0), 32'd1);
      chk("rr_g2_res", 32'(PortReserved), 32'b0010);
      step();
      chk("rr_r2_busy", 32'(outputBusy), 32'h0);
      step();
      chk("rr_g3_route", route(0), 32'd3);
      chk("rr_g3_res", 32'(PortReserved), 32'b1000);
      step();
      chk("rr_r3_busy", 32'(outputBusy), 32'h0);
      step();
      chk("rr_g4_route", route(0), 32'd0);
      req_valid = 4'b0000;
      step();
      chk("rr_end_busy", 32'(outputBusy), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);

      // 4/5a. parallel grants plus an out-of-range request
      req_valid = 4'b1011;
      set_dest(0, 2); set_dest(1, 7); set_dest(3, 0);
      step();
      chk("par_busy", 32'(outputBusy), 32'b0101);
      chk("par_route0", route(0), 32'd3);
      chk("par_route2", route(2), 32'd0);
      chk("par_route1", route(1), 32'd4);
      chk("par_route3", route(3), 32'd4);
      chk("par_res", 32'(PortReserved), 32'b1001);
      req_valid = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("oor_busy", 32'(outputBusy), 32'b0101);
         chk("oor_res", 32'(PortReserved), 32'b1001);
      end
      hs(4'b0001, 4'b0001, 4'b0001);
      step();
      chk("par_rel0_busy", 32'(outputBusy), 32'b0001);
      chk("par_rel0_route2", route(2), 32'd4);
      chk("par_rel0_res", 32'(PortReserved), 32'b1000);
      hs(4'b1000, 4'b1000, 4'b1000);
      step();
      chk("par_rel3_busy", 32'(outputBusy), 32'h0);
      chk("par_rel3_res", 32'(PortReserved), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);
      req_valid = 4'b0000;

      // 5b. asynchronous reset while output 3 is busy
      req_valid = 4'b0100;
      set_dest(2, 3);
      step();
      chk("pre_rst_busy", 32'(outputBusy), 32'b1000);
      chk("pre_rst_route3", route(3), 32'd2);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(outputBusy), 32'h0);
      chk("async_rst_res", 32'(PortReserved), 32'h0);
      chk("async_rst_route3", route(3), 32'd4);
      #1;
      rst = 1'b0;
      req_valid = 4'b1100;
      set_dest(2, 1); set_dest(3, 1);
      step();
      chk("ptr_reset_route1", route(1), 32'd2);
      chk("ptr_reset_busy", 32'(outputBusy), 32'b0010);
      chk("ptr_reset_res", 32'(PortReserved), 32'b0100);
      req_valid = 4'b1000;
      hs(4'b0100, 4'b0100, 4'b0100);
      step();
      chk("gap_busy", 32'(outputBusy), 32'h0);
      chk("gap_res", 32'(PortReserved), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);
      step();
      chk("regrant_route1", route(1), 32'd3);
      chk("regrant_res", 32'(PortReserved), 32'b1000);
      req_valid = 4'b0000;
      hs(4'b1000, 4'b1000, 4'b1000);
      step();
      chk("regrant_rel_busy", 32'(outputBusy), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);

      // 6. stalled owner: watchdog release when enabled, indefinite hold otherwise
      req_valid = 4'b0010;
      set_dest(1, 2);
      hs(4'b0010, 4'b0000, 4'b0000);
      step();
      chk("stall_grant_busy", 32'(outputBusy), 32'b0100);
      chk("stall_grant_route2", route(2), 32'd1);
      req_valid = 4'b0000;
`ifdef ALLOC_TIMEOUT_EN
      for (int c = 1; c < 8; c++) begin
         step();
         chk("wd_hold_busy", 32'(outputBusy), 32'b0100);
         chk("wd_hold_err", 32'(alloc_error), 32'h0);
      end
      step();
      chk("wd_rel_busy", 32'(outputBusy), 32'h0);
      chk("wd_rel_err", 32'(alloc_error), 32'h1);
      chk("wd_rel_res", 32'(PortReserved), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);
`else
      for (int c = 0; c < 20; c++) begin
         step();
         chk("hold_busy", 32'(outputBusy), 32'b0100);
         chk("hold_err", 32'(alloc_error), 32'h0);
      end
      hs(4'b0010, 4'b0010, 4'b0010);
      step();
      chk("hold_rel_busy", 32'(outputBusy), 32'h0);
      chk("hold_rel_res", 32'(PortReserved), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);
`endif
      req_valid = 4'b1010;
      set_dest(3, 2);
      step();
      chk("ptr_adv_route2", route(2), 32'd3);
      chk("ptr_adv_res", 32'(PortReserved), 32'b1000);
      chk("ptr_adv_err", 32'(alloc_error), 32'h0);
      req_valid = 4'b0000;
      hs(4'b1000, 4'b1000, 4'b1000);
      step();
      chk("final_busy", 32'(outputBusy), 32'h0);
      hs(4'b0000, 4'b0000, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
